// File: rtl/i2s_pkg.sv
// i2s_pkg: I2S frame geometry and the stereo sample type.
// Shared by the transmitter and the microphone receiver.
package i2s_pkg;
  localparam int SAMPLE_WIDTH = 24;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_SLOTS = 64;
  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen: divides clk_in down to the I2S bit clock.
// The rise/fall strobes mark the clk_in cycle on which sck toggles.
module i2s_sck_gen #(
  parameter int SCK_HALF = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);
  localparam int CW = $clog2(SCK_HALF);
  logic [CW-1:0] cnt_q, cnt_d;
  logic sck_q, sck_d, wrap;
  always_comb begin
    wrap = cnt_q == CW'(SCK_HALF - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    sck_d = sck_q ^ wrap;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end
  assign sck = sck_q;
  assign sck_rise = wrap && !sck_q;
  assign sck_fall = wrap && sck_q;
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: stereo I2S master with a single-entry holding register.
// A new frame is loaded from the holding register on the falling edge entering slot 0.
module i2s_transmitter
  import i2s_pkg::SLOT_BITS, i2s_pkg::FRAME_SLOTS;
#(
  parameter int SCK_HALF = 16,
  parameter int SAMPLE_WIDTH = i2s_pkg::SAMPLE_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_left_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    i2s_sck_out,
  output logic                    i2s_ws_out,
  output logic                    i2s_sd_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);
  localparam int SW = $clog2(FRAME_SLOTS);
  localparam int PW = $clog2(SLOT_BITS);
  localparam logic [PW-1:0] LAST = PW'(SAMPLE_WIDTH);
  logic sck, sck_fall, sck_rise_unused;
  logic [SW-1:0] slot_q, slot_d, slot_n;
  logic [PW-1:0] pos;
  logic right_half, data_slot, load, accept, shift_l, shift_r;
  logic ws_q, ws_d, sd_q, sd_d, hold_full_q, hold_full_d;
  logic frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [SAMPLE_WIDTH-1:0] hold_left_q, hold_left_d, hold_right_q, hold_right_d;
  logic [SAMPLE_WIDTH-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d;
  i2s_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sck      (sck),
    .sck_rise (sck_rise_unused),
    .sck_fall (sck_fall)
  );
  // Everything below is decided from the slot being entered on this falling edge.
  always_comb begin
    slot_n = slot_q + 1'b1;
    pos = slot_n[PW-1:0];
    right_half = slot_n[PW];
    data_slot = pos != '0 && pos <= LAST;
    load = sck_fall && slot_n == '0;
    accept = sample_valid_in && !hold_full_q;
    shift_l = sck_fall && data_slot && !right_half;
    shift_r = sck_fall && data_slot && right_half;
    slot_d = sck_fall ? slot_n : slot_q;
    ws_d = sck_fall ? right_half : ws_q;
    sd_d = shift_l ? left_sr_q[SAMPLE_WIDTH-1] :
           shift_r ? right_sr_q[SAMPLE_WIDTH-1] :
           sck_fall ? 1'b0 : sd_q;
    left_sr_d = load ? (hold_full_q ? hold_left_q : '0) : shift_l ? left_sr_q << 1 : left_sr_q;
    right_sr_d = load ? (hold_full_q ? hold_right_q : '0) : shift_r ? right_sr_q << 1 : right_sr_q;
    hold_full_d = load ? accept : hold_full_q || accept;
    hold_left_d = accept ? sample_left_in : hold_left_q;
    hold_right_d = accept ? sample_right_in : hold_right_q;
    frame_start_d = load;
    underrun_d = load && !hold_full_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      slot_q <= SW'(FRAME_SLOTS - 1);
      ws_q <= 1'b1;
      sd_q <= 1'b0;
      hold_full_q <= 1'b0;
      hold_left_q <= '0;
      hold_right_q <= '0;
      left_sr_q <= '0;
      right_sr_q <= '0;
      frame_start_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      ws_q <= ws_d;
      sd_q <= sd_d;
      hold_full_q <= hold_full_d;
      hold_left_q <= hold_left_d;
      hold_right_q <= hold_right_d;
      left_sr_q <= left_sr_d;
      right_sr_q <= right_sr_d;
      frame_start_q <= frame_start_d;
      underrun_q <= underrun_d;
    end
  end
  assign sample_ready_out = !hold_full_q;
  assign i2s_sck_out = sck;
  assign i2s_ws_out = ws_q;
  assign i2s_sd_out = sd_q;
  assign frame_start_out = frame_start_q;
  assign underrun_out = underrun_q;
endmodule
